// File: rtl/lcd_char_driver_pkg.sv
// Shared LCD definitions: HD44780 command bytes, FSM state/phase encodings and small helpers.
package lcd_char_driver_pkg;

  localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  // Fixed HD44780 init waits after the first two 0x3 nibbles.
  localparam int unsigned T_INIT1_US = 4100;
  localparam int unsigned T_INIT2_US = 100;

  // Top-level sequencer states.
  localparam logic [2:0] ST_PWR_WAIT    = 3'd0;
  localparam logic [2:0] ST_INIT        = 3'd1;
  localparam logic [2:0] ST_CFG         = 3'd2;
  localparam logic [2:0] ST_FRAME_START = 3'd3;
  localparam logic [2:0] ST_ADDR1       = 3'd4;
  localparam logic [2:0] ST_CHARS1      = 3'd5;
  localparam logic [2:0] ST_ADDR2       = 3'd6;
  localparam logic [2:0] ST_CHARS2      = 3'd7;

  // Per-transfer phase within a sending state.
  localparam logic [2:0] PH_LOAD  = 3'd0;
  localparam logic [2:0] PH_HI    = 3'd1;
  localparam logic [2:0] PH_HI_WT = 3'd2;
  localparam logic [2:0] PH_GAP   = 3'd3;
  localparam logic [2:0] PH_LO    = 3'd4;
  localparam logic [2:0] PH_LO_WT = 3'd5;
  localparam logic [2:0] PH_WAIT  = 3'd6;

  // Nibble transmitter states.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SETUP = 2'd1;
  localparam logic [1:0] TX_PULSE = 2'd2;
  localparam logic [1:0] TX_HOLD  = 2'd3;

  // Char k sits at s[255-8k -: 8]; 255-8k == {~k, 3'b111} for a 5-bit k.
  function automatic logic [7:0] char_at(input logic [255:0] s, input logic [4:0] k);
    char_at = s[{~k, 3'b111} -: 8];
  endfunction

  // Configuration byte sequence sent after the 4-bit switch.
  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    cfg_byte = LCD_FUNC_4BIT;
      2'd1:    cfg_byte = LCD_DISP_ON;
      2'd2:    cfg_byte = LCD_ENTRY_INC;
      default: cfg_byte = LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble LCD write: drives rs/dat, waits setup, pulses lcd_e, holds, then pulses done.
module lcd_nibble_tx
  import lcd_char_driver_pkg::*;
#(
  parameter int unsigned E_PULSE_CYC = 12,
  parameter int unsigned SETUP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] dat,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_dat
);

  localparam int unsigned CNT_MAX = (E_PULSE_CYC > SETUP_CYC) ? E_PULSE_CYC : SETUP_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYC - 1);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          e_nx, rs_nx, done_nx;
  logic [3:0]    dat_nx;

  // State and output registers; reset drops lcd_e on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_dat <= 4'h0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lcd_e   <= e_nx;
      lcd_rs  <= rs_nx;
      lcd_dat <= dat_nx;
      done    <= done_nx;
    end
  end

  // Setup -> pulse -> hold sequencing; rs/dat only change when a new nibble starts.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    e_nx     = lcd_e;
    rs_nx    = lcd_rs;
    dat_nx   = lcd_dat;
    done_nx  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (start) begin
          rs_nx    = rs;
          dat_nx   = dat;
          cnt_nx   = SETUP_LD;
          state_nx = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (cnt == '0) begin
          e_nx     = 1'b1;
          cnt_nx   = PULSE_LD;
          state_nx = TX_PULSE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      TX_PULSE: begin
        if (cnt == '0) begin
          e_nx     = 1'b0;
          cnt_nx   = SETUP_LD;
          state_nx = TX_HOLD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        if (cnt == '0) begin
          done_nx  = 1'b1;
          state_nx = TX_IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/lcd_char_driver.sv
// HD44780 16x2 driver, 4-bit write-only: power-up init, then continuous two-line refresh
// from a per-frame snapshot of strdata. Optional LCD_SKIP_SAME_EN holds off unchanged frames.
module lcd_char_driver
  import lcd_char_driver_pkg::*;
#(
  parameter int unsigned CLK_MHZ      = 50,
  parameter int unsigned T_POWERUP_US = 20000,
  parameter int unsigned T_CMD_US     = 40,
  parameter int unsigned T_CLEAR_US   = 1640,
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned SETUP_CYC    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         frame_done,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [3:0]   lcd_dat
);

  localparam int unsigned T_MAX_US = (T_POWERUP_US > T_INIT1_US) ? T_POWERUP_US : T_INIT1_US;
  localparam int unsigned TW       = $clog2(CLK_MHZ * T_MAX_US + 1);
  localparam logic [TW-1:0] LD_PWR   = TW'(CLK_MHZ * T_POWERUP_US - 1);
  localparam logic [TW-1:0] LD_INIT1 = TW'(CLK_MHZ * T_INIT1_US - 1);
  localparam logic [TW-1:0] LD_INIT2 = TW'(CLK_MHZ * T_INIT2_US - 1);
  localparam logic [TW-1:0] LD_CMD   = TW'(CLK_MHZ * T_CMD_US - 1);
  localparam logic [TW-1:0] LD_CLEAR = TW'(CLK_MHZ * T_CLEAR_US - 1);
  localparam logic [TW-1:0] LD_GAP   = TW'(E_PULSE_CYC - 1);

  logic [2:0]    state, state_nx, phase, phase_nx;
  logic [4:0]    idx, idx_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [255:0]  frame_buf, frame_buf_nx;
  logic          busy_nx, frame_done_nx;
  logic [7:0]    op_byte_c;
  logic          op_rs_c, op_single_c;
  logic [TW-1:0] op_wait_c;
  logic          tx_start_c, tx_rs_c, tx_done;
  logic [3:0]    tx_dat_c;
  logic          frame_go_c;

  assign lcd_rw = 1'b0;

`ifdef LCD_SKIP_SAME_EN
  // frame_buf doubles as the last-written frame; prev_valid forces the first frame after reset.
  logic prev_valid;
  assign frame_go_c = !(prev_valid && (strdata == frame_buf));

  // Marks frame_buf as holding a written frame once the first snapshot is taken.
  always_ff @(posedge clk) begin
    if (rst) prev_valid <= 1'b0;
    else     prev_valid <= prev_valid | (state == ST_FRAME_START);
  end
`else
  assign frame_go_c = 1'b1;
`endif

  lcd_nibble_tx #(
    .E_PULSE_CYC(E_PULSE_CYC),
    .SETUP_CYC  (SETUP_CYC)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (tx_start_c),
    .rs     (tx_rs_c),
    .dat    (tx_dat_c),
    .done   (tx_done),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_dat(lcd_dat)
  );

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PWR_WAIT;
      phase      <= PH_LOAD;
      idx        <= 5'd0;
      timer      <= '0;
      frame_buf  <= '0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      idx        <= idx_nx;
      timer      <= timer_nx;
      frame_buf  <= frame_buf_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
    end
  end

  // What the current state sends: byte or lone nibble, register select, and the wait after it.
  always_comb begin
    op_byte_c   = 8'h00;
    op_rs_c     = 1'b0;
    op_single_c = 1'b0;
    op_wait_c   = LD_CMD;
    case (state)
      ST_INIT: begin
        op_single_c = 1'b1;
        op_byte_c   = (idx == 5'd3) ? 8'h02 : 8'h03;
        if (idx == 5'd0)      op_wait_c = LD_INIT1;
        else if (idx == 5'd1) op_wait_c = LD_INIT2;
      end
      ST_CFG: begin
        op_byte_c = cfg_byte(idx[1:0]);
        if (op_byte_c == LCD_CLEAR) op_wait_c = LD_CLEAR;
      end
      ST_ADDR1: op_byte_c = LCD_LINE1;
      ST_ADDR2: op_byte_c = LCD_LINE2;
      ST_CHARS1, ST_CHARS2: begin
        op_byte_c = char_at(frame_buf, idx);
        op_rs_c   = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: nibble/gap/nibble/wait phases inside each state, then advance the state.
  always_comb begin
    state_nx      = state;
    phase_nx      = phase;
    idx_nx        = idx;
    timer_nx      = timer;
    frame_buf_nx  = frame_buf;
    busy_nx       = busy;
    frame_done_nx = 1'b0;
    tx_start_c    = 1'b0;
    tx_rs_c       = op_rs_c;
    tx_dat_c      = op_byte_c[7:4];
    if (state == ST_FRAME_START) begin
      if (frame_go_c) begin
        frame_buf_nx = strdata;
        busy_nx      = 1'b0;
        state_nx     = ST_ADDR1;
        phase_nx     = PH_HI;
      end
    end else begin
      case (phase)
        PH_LOAD: begin
          timer_nx = LD_PWR;
          phase_nx = PH_WAIT;
        end
        PH_HI: begin
          tx_start_c = 1'b1;
          tx_dat_c   = op_single_c ? op_byte_c[3:0] : op_byte_c[7:4];
          phase_nx   = PH_HI_WT;
        end
        PH_HI_WT: begin
          if (tx_done) begin
            timer_nx = op_single_c ? op_wait_c : LD_GAP;
            phase_nx = op_single_c ? PH_WAIT : PH_GAP;
          end
        end
        PH_GAP: begin
          if (timer == '0) phase_nx = PH_LO;
          else             timer_nx = timer - TW'(1);
        end
        PH_LO: begin
          tx_start_c = 1'b1;
          tx_dat_c   = op_byte_c[3:0];
          phase_nx   = PH_LO_WT;
        end
        PH_LO_WT: begin
          if (tx_done) begin
            timer_nx = op_wait_c;
            phase_nx = PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (timer != '0) begin
            timer_nx = timer - TW'(1);
          end else begin
            phase_nx = PH_HI;
            case (state)
              ST_PWR_WAIT: begin
                state_nx = ST_INIT;
                idx_nx   = 5'd0;
              end
              ST_INIT: begin
                idx_nx = (idx == 5'd3) ? 5'd0 : idx + 5'd1;
                if (idx == 5'd3) state_nx = ST_CFG;
              end
              ST_CFG: begin
                idx_nx = (idx == 5'd3) ? 5'd0 : idx + 5'd1;
                if (idx == 5'd3) state_nx = ST_FRAME_START;
              end
              ST_ADDR1: state_nx = ST_CHARS1;
              ST_CHARS1: begin
                idx_nx = idx + 5'd1;
                if (idx == 5'd15) state_nx = ST_ADDR2;
              end
              ST_ADDR2: state_nx = ST_CHARS2;
              ST_CHARS2: begin
                idx_nx = idx + 5'd1;
                if (idx == 5'd31) begin
                  state_nx      = ST_FRAME_START;
                  frame_done_nx = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: phase_nx = PH_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Scoreboard bench for lcd_char_driver: expected nibbles queued from an LCD-protocol model,
// popped by a bus monitor on every lcd_e falling edge.
module tb_lcd_char_driver;

  localparam int unsigned CLK_MHZ = 1;
  localparam int unsigned T_PU    = 50;
  localparam int unsigned T_CMD   = 4;
  localparam int unsigned T_CLR   = 8;
  localparam int unsigned E_P     = 2;
  localparam int unsigned SU      = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] strdata;
  logic         busy, frame_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_dat;

  always #5 clk = ~clk;

  lcd_char_driver #(
    .CLK_MHZ(CLK_MHZ), .T_POWERUP_US(T_PU), .T_CMD_US(T_CMD), .T_CLEAR_US(T_CLR),
    .E_PULSE_CYC(E_P), .SETUP_CYC(SU)
  ) dut (
    .clk(clk), .rst(rst), .strdata(strdata), .busy(busy), .frame_done(frame_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_dat(lcd_dat)
  );

  int checks = 0, errors = 0;
  int rises = 0, falls = 0, fd_cnt = 0, frames_exp = 0;
  logic [4:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
    end
  endtask

  // Model: a byte goes out as high nibble then low nibble with the same rs.
  task automatic push_byte(input logic rs_v, input logic [7:0] b);
    sb.push_back({rs_v, b[7:4]});
    sb.push_back({rs_v, b[3:0]});
  endtask

  task automatic push_init();
    sb.push_back(5'h03); sb.push_back(5'h03); sb.push_back(5'h03); sb.push_back(5'h02);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06); push_byte(1'b0, 8'h01);
  endtask

  // Model: line-1 address, chars 0-15, line-2 address, chars 16-31 (first char in the MSBs).
  task automatic push_frame(input logic [255:0] s);
    logic [255:0] t;
    t = s;
    push_byte(1'b0, 8'h80);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) push_byte(1'b0, 8'hC0);
      push_byte(1'b1, t[255:248]);
      t = t << 8;
    end
  endtask

  function automatic logic [255:0] rand_str(input logic [255:0] cur);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    if (r == cur) r[7:0] = r[7:0] ^ 8'h01;
    return r;
  endfunction

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
    end else begin
      frames_exp++;
      chk("nibbles_left_at_frame_done", sb.size(), 0);
      chk("busy_in_frame", 32'(busy), 0);
    end
  endtask

  // Bus monitor: timing checks and scoreboard pop on each lcd_e falling edge.
  logic       pe = 1'b0;
  logic [4:0] prev_bus = 5'h0, bus, exp_n;
  int         stable = 0, high = 0, since_fall = 1000, cyc = 0;
  bit         first_pending = 1'b1;

  always @(negedge clk) begin
    bus = {lcd_rs, lcd_dat};
    if (rst) begin
      pe = 1'b0; cyc = 0; first_pending = 1'b1; stable = 0; high = 0; since_fall = 1000;
      prev_bus = bus;
    end else begin
      cyc++;
      if (frame_done) fd_cnt++;
      if (bus != prev_bus) begin
        if (since_fall < 1000) chk_min("hold_after_e_fall", since_fall, SU);
        stable = 1;
      end else if (stable < 1000) begin
        stable++;
      end
      if (lcd_e && !pe) begin
        rises++;
        chk_min("setup_before_e_rise", stable - 1, SU);
        if (first_pending) begin
          chk_min("powerup_cycles_before_first_e", cyc, T_PU);
          first_pending = 1'b0;
        end
        high = 0;
      end
      if (lcd_e) high++;
      if (!lcd_e && pe) begin
        falls++;
        chk_min("e_pulse_width", high, E_P);
        since_fall = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_nibble: got rs=%0d dat=0x%0h with none expected", lcd_rs, lcd_dat);
        end else begin
          exp_n = sb.pop_front();
          chk("nibble_rs_dat", 32'(bus), 32'(exp_n));
        end
      end else if (since_fall < 1000) begin
        since_fall++;
      end
      pe = lcd_e;
      prev_bus = bus;
    end
  end

  initial begin
    int n, base;
    int r0, d0;
    rst = 1'b1;
    strdata = "0123456789ABCDEFGHIJKLMNOPQRSTUV";
    repeat (3) @(negedge clk);
    chk("reset_lcd_e", 32'(lcd_e), 0);
    chk("reset_lcd_rs", 32'(lcd_rs), 0);
    chk("reset_lcd_rw", 32'(lcd_rw), 0);
    chk("reset_lcd_dat", 32'(lcd_dat), 0);
    chk("reset_busy", 32'(busy), 1);
    chk("reset_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    push_init();
    push_frame(strdata);
    repeat (40) @(negedge clk);
    chk("busy_during_powerup", 32'(busy), 1);
    wait_done(8000);

`ifdef LCD_SKIP_SAME_EN
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 0);
    r0 = rises; d0 = fd_cnt;
    repeat (300) @(negedge clk);
    chk("skip_same_no_e_pulses", rises - r0, 0);
    chk("skip_same_no_frame_done", fd_cnt - d0, 0);
    strdata[199:192] = strdata[199:192] ^ 8'h5A;
    push_frame(strdata);
    base = falls;
`else
    base = falls;
    push_frame(strdata);
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 0);
`endif

    // Change the string after the 5th char of the running frame; it must show next frame only.
    n = 0;
    while (falls < base + 12 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_frame_reached", 32'(falls >= base + 12), 1);
    strdata = rand_str(strdata);
    wait_done(3000);
    push_frame(strdata);
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 0);

    for (int f = 0; f < 2; f++) begin
      wait_done(3000);
      strdata = rand_str(strdata);
      push_frame(strdata);
      @(negedge clk);
      chk("frame_done_one_cycle", 32'(frame_done), 0);
    end

    // Reset while lcd_e is high: strobe drops next edge, full power-up and init repeat.
    n = 0;
    while (!lcd_e && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("e_high_before_reset", 32'(lcd_e), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("lcd_e_low_after_rst", 32'(lcd_e), 0);
    sb.delete();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_lcd_rs", 32'(lcd_rs), 0);
    chk("rst_lcd_dat", 32'(lcd_dat), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    push_init();
    push_frame(strdata);
    repeat (40) @(negedge clk);
    chk("busy_after_rst", 32'(busy), 1);
    wait_done(8000);
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 0);
    chk("frame_done_total", fd_cnt, frames_exp);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
